trap_ctrl: RTL and testbench

Trap sequencer that sits directly upstream of the CSR file. Each cycle it collects synchronous exception flags from execute, selects one by RISC-V priority and drives the CSR file's one-cycle trap request (cause, value, PC). It then waits for the trap-handled handshake and issues a single PC redirect to the returned vector. It also turns `mret` into a redirect to mepc, and stalls the pipeline for the whole sequence.

---
 rtl/trap_ctrl.sv | 128 ++++++++++++
 tb/tb_trap_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap sequencer between execute and the CSR file
// Prioritises synchronous exceptions, handshakes with the CSR file, and issues one PC redirect per trap or mret.
module trap_ctrl #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    TIMEOUT    = 15,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] pc_i,
   input  logic [31:0]           instr_i,
   input  logic [DATA_WIDTH-1:0] addr_i,
   input  logic                  exc_fetch_misaligned_i,
   input  logic                  exc_illegal_i,
   input  logic                  exc_ebreak_i,
   input  logic                  exc_ecall_i,
   input  logic                  exc_load_misaligned_i,
   input  logic                  exc_store_misaligned_i,
   input  logic                  mret_i,
   input  logic [DATA_WIDTH-1:0] mepc_i,
   output logic                  trap_o,
   output logic [3:0]            trap_cause_o,
   output logic [DATA_WIDTH-1:0] trap_value_o,
   output logic [DATA_WIDTH-1:0] trap_pc_o,
   input  logic                  trap_handled_i,
   input  logic [DATA_WIDTH-1:0] trap_target_pc_i,
   output logic                  stall_o,
   output logic                  redirect_valid_o,
   output logic [DATA_WIDTH-1:0] redirect_pc_o,
   output logic                  timeout_err_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_REDIRECT} state_t;

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic                    exc_any;
   logic [3:0]              sel_cause;
   logic [DATA_WIDTH-1:0]   sel_value;

   assign exc_any = valid_i & (exc_fetch_misaligned_i | exc_illegal_i | exc_ebreak_i |
                               exc_ecall_i | exc_load_misaligned_i | exc_store_misaligned_i);

   // Stall asserts in the same cycle the exception/mret is seen, before the FSM leaves IDLE.
   assign stall_o = (state != S_IDLE) | exc_any | (valid_i & mret_i);

   always_comb begin
      sel_cause = 4'd0;
      sel_value = '0;
      if (exc_fetch_misaligned_i) begin
         sel_cause = 4'd0;
         sel_value = addr_i;
      end else if (exc_illegal_i) begin
         sel_cause = 4'd2;
         sel_value = DATA_WIDTH'(instr_i);
      end else if (exc_ebreak_i) begin
         sel_cause = 4'd3;
      end else if (exc_ecall_i) begin
         sel_cause = 4'd11;
      end else if (exc_load_misaligned_i) begin
         sel_cause = 4'd4;
         sel_value = addr_i;
      end else if (exc_store_misaligned_i) begin
         sel_cause = 4'd6;
         sel_value = addr_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         cnt              <= '0;
         trap_o           <= 1'b0;
         trap_cause_o     <= 4'd0;
         trap_value_o     <= '0;
         trap_pc_o        <= '0;
         redirect_valid_o <= 1'b0;
         redirect_pc_o    <= '0;
         timeout_err_o    <= 1'b0;
      end else begin
         trap_o           <= 1'b0;
         redirect_valid_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (exc_any) begin
                  state        <= S_REQ;
                  trap_o       <= 1'b1;
                  trap_cause_o <= sel_cause;
                  trap_value_o <= sel_value;
                  trap_pc_o    <= pc_i;
               end else if (valid_i && mret_i) begin
                  state            <= S_REDIRECT;
                  redirect_valid_o <= 1'b1;
                  redirect_pc_o    <= {mepc_i[DATA_WIDTH-1:2], 2'b00};
               end
            end
            S_REQ: begin
               state <= S_WAIT;
               cnt   <= '0;
            end
            S_WAIT: begin
               cnt <= cnt + 1'b1;
               // The acknowledge is checked first so it wins on the final wait cycle.
               if (trap_handled_i) begin
                  state            <= S_REDIRECT;
                  redirect_valid_o <= 1'b1;
                  redirect_pc_o    <= {trap_target_pc_i[DATA_WIDTH-1:2], 2'b00};
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  state            <= S_REDIRECT;
                  redirect_valid_o <= 1'b1;
                  redirect_pc_o    <= RESET_PC;
                  timeout_err_o    <= 1'b1;
               end
            end
            S_REDIRECT: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - scoreboard testbench for trap_ctrl
// Directed traps and mrets push expected CSR requests and redirects; a negedge monitor pops and compares.
module tb_trap_ctrl;

   localparam int          TIMEOUT  = 15;
   localparam logic [31:0] RESET_PC = 32'h0000_0080;

   logic        clk, rst_n;
   logic        valid_i, mret_i, trap_handled_i;
   logic [31:0] pc_i, instr_i, addr_i, mepc_i, trap_target_pc_i;
   logic        exc_fetch_misaligned_i, exc_illegal_i, exc_ebreak_i, exc_ecall_i;
   logic        exc_load_misaligned_i, exc_store_misaligned_i;
   logic        trap_o, stall_o, redirect_valid_o, timeout_err_o;
   logic [3:0]  trap_cause_o;
   logic [31:0] trap_value_o, trap_pc_o, redirect_pc_o;

   typedef struct {logic [3:0] cause; logic [31:0] value; logic [31:0] pc;} trap_t;
   typedef struct {logic [31:0] pc; logic err;} redir_t;

   trap_t  trap_q[$];
   redir_t redir_q[$];
   trap_t  te;
   redir_t re;
   int     n_chk = 0;
   int     n_fail = 0;
   logic   err_sticky = 1'b0;

   trap_ctrl #(.DATA_WIDTH(32), .TIMEOUT(TIMEOUT), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i), .addr_i(addr_i),
      .exc_fetch_misaligned_i(exc_fetch_misaligned_i), .exc_illegal_i(exc_illegal_i),
      .exc_ebreak_i(exc_ebreak_i), .exc_ecall_i(exc_ecall_i),
      .exc_load_misaligned_i(exc_load_misaligned_i), .exc_store_misaligned_i(exc_store_misaligned_i),
      .mret_i(mret_i), .mepc_i(mepc_i), .trap_o(trap_o), .trap_cause_o(trap_cause_o),
      .trap_value_o(trap_value_o), .trap_pc_o(trap_pc_o), .trap_handled_i(trap_handled_i),
      .trap_target_pc_i(trap_target_pc_i), .stall_o(stall_o), .redirect_valid_o(redirect_valid_o),
      .redirect_pc_o(redirect_pc_o), .timeout_err_o(timeout_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid_i = 0; mret_i = 0; trap_handled_i = 0;
      {exc_fetch_misaligned_i, exc_illegal_i, exc_ebreak_i, exc_ecall_i,
       exc_load_misaligned_i, exc_store_misaligned_i} = 6'b0;
   endtask

   always @(negedge clk) begin
      if (trap_o) begin
         if (trap_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_trap: got cause %0d pc %h expected no trap", trap_cause_o, trap_pc_o);
         end else begin
            te = trap_q.pop_front();
            chk("trap_cause", {28'b0, trap_cause_o}, {28'b0, te.cause});
            chk("trap_value", trap_value_o, te.value);
            chk("trap_pc", trap_pc_o, te.pc);
         end
      end
      if (redirect_valid_o) begin
         if (redir_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_redirect: got pc %h expected no redirect", redirect_pc_o);
         end else begin
            re = redir_q.pop_front();
            chk("redirect_pc", redirect_pc_o, re.pc);
            chk("redirect_err", {31'b0, timeout_err_o}, {31'b0, re.err});
         end
      end
   end

   // flags = {fetch, illegal, ebreak, ecall, load, store}; ack_at = WAIT cycle of the ack, 0 = never
   task automatic run_trap(input logic [5:0] flags, input logic mret, input logic [31:0] pc,
                           input logic [31:0] instr, input logic [31:0] addr,
                           input logic [3:0] cause, input logic [31:0] value,
                           input logic [31:0] target, input logic [31:0] exp_pc, input int ack_at);
      trap_q.push_back('{cause, value, pc});
      if (ack_at == 0) err_sticky = 1'b1;
      redir_q.push_back('{exp_pc, err_sticky});
      valid_i = 1; mret_i = mret; pc_i = pc; instr_i = instr; addr_i = addr;
      {exc_fetch_misaligned_i, exc_illegal_i, exc_ebreak_i, exc_ecall_i,
       exc_load_misaligned_i, exc_store_misaligned_i} = flags;
      #1 chk("stall_c0", {31'b0, stall_o}, 1);
      tick();
      idle_inputs();
      chk("trap_c1", {31'b0, trap_o}, 1);
      chk("stall_c1", {31'b0, stall_o}, 1);
      tick();
      for (int i = 1; i <= TIMEOUT; i++) begin
         if (i == ack_at) begin
            trap_handled_i = 1; trap_target_pc_i = target;
            tick();
            trap_handled_i = 0;
            break;
         end
         tick();
      end
      chk("redirect_cycle", {31'b0, redirect_valid_o}, 1);
      chk("stall_redirect", {31'b0, stall_o}, 1);
      tick();
      chk("redirect_once", {31'b0, redirect_valid_o}, 0);
      chk("stall_idle", {31'b0, stall_o}, 0);
   endtask

   task automatic run_mret(input logic [31:0] mepc, input logic [31:0] exp_pc);
      redir_q.push_back('{exp_pc, err_sticky});
      valid_i = 1; mret_i = 1; mepc_i = mepc;
      #1 chk("stall_mret", {31'b0, stall_o}, 1);
      tick();
      idle_inputs();
      chk("mret_redirect", {31'b0, redirect_valid_o}, 1);
      chk("mret_no_trap", {31'b0, trap_o}, 0);
      tick();
   endtask

   initial begin
      rst_n = 0;
      idle_inputs();
      pc_i = 0; instr_i = 0; addr_i = 0; mepc_i = 0; trap_target_pc_i = 0;
      #12;
      chk("rst_trap", {31'b0, trap_o}, 0);
      chk("rst_cause", {28'b0, trap_cause_o}, 0);
      chk("rst_value", trap_value_o, 0);
      chk("rst_pc", trap_pc_o, 0);
      chk("rst_redirect", {31'b0, redirect_valid_o}, 0);
      chk("rst_redirect_pc", redirect_pc_o, 0);
      chk("rst_err", {31'b0, timeout_err_o}, 0);
      chk("rst_stall", {31'b0, stall_o}, 0);
      tick();
      rst_n = 1;
      tick();

      run_trap(6'b000100, 0, 32'h100, 32'h0000_0073, 32'h1111_0000, 4'd11, 32'h0, 32'h204, 32'h204, 1);
      run_trap(6'b010110, 0, 32'h104, 32'hFFFF_FFFF, 32'h2000, 4'd2, 32'hFFFF_FFFF, 32'h300, 32'h300, 1);
      run_trap(6'b000010, 0, 32'h108, 32'h0000_0013, 32'h1003, 4'd4, 32'h1003, 32'h207, 32'h204, 2);
      run_trap(6'b000001, 0, 32'h10C, 32'h0000_0013, 32'h1003, 4'd6, 32'h1003, 32'h208, 32'h208, 1);
      run_trap(6'b100001, 0, 32'h110, 32'h0000_0013, 32'h55, 4'd0, 32'h55, 32'h20C, 32'h20C, 1);
      run_trap(6'b001100, 0, 32'h114, 32'h0010_0073, 32'h77, 4'd3, 32'h0, 32'h210, 32'h210, 1);

      run_mret(32'h0000_0107, 32'h104);
      run_mret(32'h0000_2002, 32'h2000);
      run_trap(6'b001000, 1, 32'h118, 32'h0010_0073, 32'h99, 4'd3, 32'h0, 32'h400, 32'h400, 1);

      run_trap(6'b000100, 0, 32'h120, 32'h0000_0073, 32'h0, 4'd11, 32'h0, 32'h500, 32'h500, TIMEOUT);
      chk("no_err_on_late_ack", {31'b0, timeout_err_o}, 0);
      run_trap(6'b000100, 0, 32'h124, 32'h0000_0073, 32'h0, 4'd11, 32'h0, 32'h600, RESET_PC, 0);
      chk("err_set", {31'b0, timeout_err_o}, 1);
      run_trap(6'b000100, 0, 32'h128, 32'h0000_0073, 32'h0, 4'd11, 32'h0, 32'h604, 32'h604, 1);
      chk("err_sticky", {31'b0, timeout_err_o}, 1);

      trap_q.push_back('{4'd11, 32'h0, 32'h300});
      valid_i = 1; exc_ecall_i = 1; pc_i = 32'h300;
      tick();
      idle_inputs();
      tick(); tick();
      rst_n = 0;
      #1;
      chk("arst_trap", {31'b0, trap_o}, 0);
      chk("arst_cause", {28'b0, trap_cause_o}, 0);
      chk("arst_value", trap_value_o, 0);
      chk("arst_pc", trap_pc_o, 0);
      chk("arst_redirect", {31'b0, redirect_valid_o}, 0);
      chk("arst_redirect_pc", redirect_pc_o, 0);
      chk("arst_err", {31'b0, timeout_err_o}, 0);
      chk("arst_stall", {31'b0, stall_o}, 0);
      err_sticky = 1'b0;
      tick();
      rst_n = 1;
      repeat (20) tick();
      run_trap(6'b000100, 0, 32'h140, 32'h0000_0073, 32'h0, 4'd11, 32'h0, 32'h704, 32'h704, 1);

      repeat (3) tick();
      chk("trap_q_drained", trap_q.size(), 0);
      chk("redir_q_drained", redir_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
